// File: rtl/uart_word_tx_pkg.sv
// Shared constants and state type for the word-wide UART transmitter.
package uart_word_tx_pkg;

  localparam int unsigned CLK_FREQ         = 50_000_000;
  localparam int unsigned UART_BPS         = 9600;
  localparam int unsigned INST_DATA_BUS    = 32;
  localparam int unsigned BAUD_CNT_DEFAULT = CLK_FREQ / UART_BPS;

  localparam int unsigned BAUD_W = 13;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BYTE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_word_tx.sv
// Sends one accepted 32-bit word as four back-to-back 8N1 frames, least-significant byte first.
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int unsigned BAUD_CNT_MAX = BAUD_CNT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tx_valid_i,
  input  logic [INST_DATA_BUS-1:0] tx_data_i,
  output logic                     tx_ready_o,
  output logic                     tx_done_o,
  output logic                     uart_tx
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);

  tx_state_e                state;
  logic [BAUD_W-1:0]        baud_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [BYTE_W-1:0]        byte_cnt;
  logic [INST_DATA_BUS-1:0] sreg;
  logic                     bit_end;

  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign tx_ready_o = (state == ST_IDLE);

  // Bit timing, framing and word sequencing; the line level is always a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      sreg      <= '0;
      uart_tx   <= 1'b1;
      tx_done_o <= 1'b0;
    end else begin
      tx_done_o <= 1'b0;

      if (state == ST_IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (tx_valid_i) begin
            sreg    <= tx_data_i;
            uart_tx <= 1'b0;
            state   <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            uart_tx <= sreg[0];
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end

        // The whole word shifts once per data bit, so sreg[0] is always the next bit due.
        ST_DATA: begin
          if (bit_end) begin
            sreg <= sreg >> 1;
            if (bit_cnt == BIT_W'(7)) begin
              uart_tx <= 1'b1;
              bit_cnt <= '0;
              state   <= ST_STOP;
            end else begin
              uart_tx <= sreg[1];
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            if (byte_cnt == BYTE_W'(3)) begin
              byte_cnt  <= '0;
              tx_done_o <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              byte_cnt <= byte_cnt + BYTE_W'(1);
              uart_tx  <= 1'b0;
              state    <= ST_START;
            end
          end
        end

        default: begin
          uart_tx <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: driver queues expected bytes and completion times, monitors decode the line.
module tb_uart_word_tx;

  localparam int B = 16;

  logic        clk;
  logic        rst_n;
  logic        tx_valid_i;
  logic [31:0] tx_data_i;
  logic        tx_ready_o;
  logic        tx_done_o;
  logic        uart_tx;

  uart_word_tx #(.BAUD_CNT_MAX(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid_i(tx_valid_i),
    .tx_data_i (tx_data_i),
    .tx_ready_o(tx_ready_o),
    .tx_done_o (tx_done_o),
    .uart_tx   (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  longint cyc = 0;

  logic [7:0] exp_bytes[$];
  longint     exp_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: expected level per cycle comes from the 8N1 frame of the expected byte.
  bit         mon_active = 0;
  int         mon_off = 0;
  int         mon_bad = 0;
  logic [7:0] mon_exp = '0;
  logic [7:0] mon_dec = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 0;
    end else begin
      if (!mon_active && uart_tx == 1'b0) begin
        mon_active = 1;
        mon_off    = 0;
        mon_bad    = 0;
        mon_dec    = '0;
        if (exp_bytes.size() == 0) begin
          check("unexpected_frame", 1, 0);
          mon_exp = '0;
        end else begin
          mon_exp = exp_bytes.pop_front();
        end
      end
      if (mon_active) begin
        int  bi;
        logic lvl;
        bi = mon_off / B;
        if (bi == 0)      lvl = 1'b0;
        else if (bi == 9) lvl = 1'b1;
        else              lvl = mon_exp[bi-1];
        if (uart_tx !== lvl) mon_bad++;
        if (bi >= 1 && bi <= 8 && (mon_off % B) == B/2) mon_dec[bi-1] = uart_tx;
        mon_off++;
        if (mon_off == 10*B) begin
          check("frame_byte", mon_dec, mon_exp);
          check("frame_bit_timing", mon_bad, 0);
          mon_active = 0;
        end
      end
    end
  end

  // Completion monitor: each done pulse must land exactly 40 bit times after acceptance.
  always @(negedge clk) begin
    if (rst_n && tx_done_o) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check("done_cycle", cyc, exp_done.pop_front());
        check("ready_at_done", tx_ready_o, 1);
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit keep_valid);
    int w;
    @(negedge clk);
    tx_valid_i = 1'b1;
    tx_data_i  = d;
    w = 0;
    while (!tx_ready_o && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) begin
      check("accept_timeout", 1, 0);
    end else begin
      for (int k = 0; k < 4; k++) exp_bytes.push_back(d[8*k +: 8]);
      exp_done.push_back(cyc + 1 + 40*B);
    end
    @(posedge clk);
    #1;
    if (!keep_valid) tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_done.size() != 0 || exp_bytes.size() != 0 || mon_active || !tx_ready_o) && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 4000) check("idle_timeout", 1, 0);
  endtask

  task automatic idle_window(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_ready_o !== 1'b1 || tx_done_o !== 1'b0) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    int busy_bad;
    rst_n      = 1'b0;
    tx_valid_i = 1'b0;
    tx_data_i  = '0;
    #22;
    check("reset_uart_tx", uart_tx, 1);
    check("reset_ready", tx_ready_o, 1);
    check("reset_done", tx_done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset release
    idle_window("idle_after_reset", 1000);

    // Single word, LSB byte first
    send(32'h44332211, 1'b0);
    wait_idle();

    // Held valid: two words back to back
    send(32'hA5A5A5A5, 1'b1);
    send(32'h0000FFFF, 1'b0);
    wait_idle();

    // Valid/data toggled while busy must be ignored
    send(32'h00000000, 1'b0);
    busy_bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready_o !== 1'b0) busy_bad++;
      tx_valid_i = 1'($urandom_range(0, 1));
      tx_data_i  = 32'hDEADBEEF;
    end
    tx_valid_i = 1'b0;
    check("ready_low_while_busy", busy_bad, 0);
    wait_idle();

    // All-ones and all-zeros frames
    send(32'hFFFFFFFF, 1'b0);
    send(32'h00000000, 1'b0);
    wait_idle();

    // Randomized words with random spacing
    for (int i = 0; i < 6; i++) begin
      send($urandom, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

    // Reset in the middle of byte1 aborts the word
    send(32'h12345678, 1'b0);
    repeat (10*B + 3*B + 5) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_line_high", uart_tx, 1);
    check("async_reset_ready", tx_ready_o, 1);
    exp_bytes.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_window("idle_after_abort", 700);

    check("pending_bytes", exp_bytes.size(), 0);
    check("pending_done", exp_done.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
